// File: rtl/traffic_pkg.sv
// Shared types for the traffic-light controller and its downstream sequence catcher.
// The state enum values double as the observable phase encoding.
package traffic_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RED        = 3'd1,
        RED_YELLOW = 3'd2,
        GREEN      = 3'd3,
        YELLOW     = 3'd4,
        BLINK_ON   = 3'd5,
        BLINK_OFF  = 3'd6
    } state_t;

    typedef struct packed {
        logic red;
        logic yellow;
        logic green;
    } ryg_t;

    function automatic ryg_t lamp_decode(input state_t s);
        ryg_t l;
        l = '0;
        case (s)
            RED:        l.red = 1'b1;
            RED_YELLOW: begin
                l.red    = 1'b1;
                l.yellow = 1'b1;
            end
            GREEN:      l.green  = 1'b1;
            YELLOW:     l.yellow = 1'b1;
            BLINK_ON:   l.yellow = 1'b1;
            default:    l = '0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_phase_timer.sv
// Down-counting phase timer: loaded with N-1 on state entry, expired when it reaches zero.
// Frozen entirely while en is low.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (load) begin
                cnt_d = load_val;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Moore traffic-light sequencer with a blinking-yellow service mode.
//
//   state      | meaning
//   IDLE       | lamps off, waiting for start (or service)
//   RED        | red, RED_CYCLES enabled cycles
//   RED_YELLOW | red+yellow, RY_CYCLES enabled cycles
//   GREEN      | green, GREEN_CYCLES enabled cycles
//   YELLOW     | yellow, YELLOW_CYCLES enabled cycles
//   BLINK_ON   | service mode, yellow lit for BLINK_CYCLES
//   BLINK_OFF  | service mode, lamps dark for BLINK_CYCLES
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int RED_CYCLES    = 4,
    parameter int RY_CYCLES     = 1,
    parameter int GREEN_CYCLES  = 3,
    parameter int YELLOW_CYCLES = 2,
    parameter int BLINK_CYCLES  = 1,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       en,
    input  logic       service,
    output logic       red,
    output logic       yellow,
    output logic       green,
    output logic [2:0] phase
);

    localparam logic [CNT_W-1:0] RED_LD    = CNT_W'(RED_CYCLES - 1);
    localparam logic [CNT_W-1:0] RY_LD     = CNT_W'(RY_CYCLES - 1);
    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLINK_LD  = CNT_W'(BLINK_CYCLES - 1);

    state_t           state_q;
    state_t           state_d;
    ryg_t             ryg_q;
    ryg_t             ryg_d;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             expired;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .expired  (expired)
    );

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_val = '0;
        if (en) begin
            if (service && state_q != BLINK_ON && state_q != BLINK_OFF) begin
                state_d  = BLINK_ON;
                load     = 1'b1;
                load_val = BLINK_LD;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_d  = RED;
                            load     = 1'b1;
                            load_val = RED_LD;
                        end
                    end
                    RED: begin
                        if (expired) begin
                            state_d  = RED_YELLOW;
                            load     = 1'b1;
                            load_val = RY_LD;
                        end
                    end
                    RED_YELLOW: begin
                        if (expired) begin
                            state_d  = GREEN;
                            load     = 1'b1;
                            load_val = GREEN_LD;
                        end
                    end
                    GREEN: begin
                        if (expired) begin
                            state_d  = YELLOW;
                            load     = 1'b1;
                            load_val = YELLOW_LD;
                        end
                    end
                    YELLOW: begin
                        if (expired) begin
                            state_d  = RED;
                            load     = 1'b1;
                            load_val = RED_LD;
                        end
                    end
                    BLINK_ON, BLINK_OFF: begin
                        // Leaving service abandons the half-period and restarts a full red.
                        if (!service) begin
                            state_d  = RED;
                            load     = 1'b1;
                            load_val = RED_LD;
                        end else if (expired) begin
                            state_d  = (state_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
                            load     = 1'b1;
                            load_val = BLINK_LD;
                        end
                    end
                    default: begin
                        state_d  = IDLE;
                        load     = 1'b1;
                        load_val = '0;
                    end
                endcase
            end
        end
    end

    assign ryg_d = lamp_decode(state_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ryg_q   <= '0;
        end else begin
            state_q <= state_d;
            ryg_q   <= ryg_d;
        end
    end

    assign red    = ryg_q.red;
    assign yellow = ryg_q.yellow;
    assign green  = ryg_q.green;
    assign phase  = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl against a timeline-based reference model.
module tb_traffic_light_ctrl;
    import traffic_pkg::*;

    localparam int R_N    = 4;
    localparam int RY_N   = 1;
    localparam int G_N    = 3;
    localparam int Y_N    = 2;
    localparam int B_N    = 1;
    localparam int PERIOD = R_N + RY_N + G_N + Y_N;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       en = 1'b0;
    logic       service = 1'b0;
    logic       red, yellow, green;
    logic [2:0] phase;

    int errors = 0;
    int checks = 0;

    // Model: mode 0 = idle, 1 = normal (pos = enabled cycles into the period), 2 = service blink
    int m_mode = 0;
    int m_pos  = 0;
    int m_bpos = 0;

    traffic_light_ctrl u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .en      (en),
        .service (service),
        .red     (red),
        .yellow  (yellow),
        .green   (green),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] model_out();
        logic [5:0] o;
        if (m_mode == 0) begin
            o = {3'b000, IDLE};
        end else if (m_mode == 1) begin
            if (m_pos < R_N)                  o = {3'b100, RED};
            else if (m_pos < R_N + RY_N)      o = {3'b110, RED_YELLOW};
            else if (m_pos < R_N + RY_N + G_N) o = {3'b001, GREEN};
            else                               o = {3'b010, YELLOW};
        end else begin
            if (((m_bpos / B_N) % 2) == 0) o = {3'b010, BLINK_ON};
            else                           o = {3'b000, BLINK_OFF};
        end
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_mode = 0;
        end else if (en) begin
            if (service && m_mode != 2) begin
                m_mode = 2;
                m_bpos = 0;
            end else if (m_mode == 0) begin
                if (start) begin
                    m_mode = 1;
                    m_pos  = 0;
                end
            end else if (m_mode == 1) begin
                m_pos = (m_pos + 1) % PERIOD;
            end else if (!service) begin
                m_mode = 1;
                m_pos  = 0;
            end else begin
                m_bpos++;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_until_pos(input int p);
        int n;
        n = 0;
        while (!(m_mode == 1 && m_pos == p) && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!(m_mode == 1 && m_pos == p)) begin
            errors++;
            $display("FAIL wait_pos: reached mode=%0d pos=%0d, required pos=%0d", m_mode, m_pos, p);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; en = 1'b1; service = 1'b0;
        tick();
        tick();
        checks++;
        if ({red, yellow, green, phase} !== {3'b000, IDLE}) begin
            errors++;
            $display("FAIL reset: got %b, required %b", {red, yellow, green, phase}, {3'b000, IDLE});
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({red, yellow, green, phase} !== model_out()) begin
            errors++;
            $display("FAIL reset_idle: got %b, required %b", {red, yellow, green, phase}, model_out());
        end
    endtask

    task automatic test_normal_cycle();
        start = 1'b1; en = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (red !== 1'b1 || phase !== RED) begin
            errors++;
            $display("FAIL start_latency: red=%b phase=%0d, required red=1 phase=%0d", red, phase, RED);
        end
        for (int i = 0; i < 2 * PERIOD + 1; i++) begin
            tick();
            checks++;
            if ({red, yellow, green, phase} !== model_out()) begin
                errors++;
                $display("FAIL normal[%0d]: got %b, required %b", i, {red, yellow, green, phase}, model_out());
            end
        end
    endtask

    task automatic test_freeze();
        run_until_pos(R_N + RY_N + 1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({red, yellow, green, phase} !== {3'b001, GREEN}) begin
                errors++;
                $display("FAIL freeze[%0d]: got %b, required %b", i, {red, yellow, green, phase}, {3'b001, GREEN});
            end
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({red, yellow, green, phase} !== model_out()) begin
                errors++;
                $display("FAIL unfreeze[%0d]: got %b, required %b", i, {red, yellow, green, phase}, model_out());
            end
        end
    endtask

    task automatic test_service();
        logic [2:0] hist;
        logic       seen;
        hist = '0;
        seen = 1'b0;
        run_until_pos(R_N + RY_N);
        service = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            hist = {hist[1:0], yellow};
            if (i < 4 && hist == 3'b101) seen = 1'b1;
            checks++;
            if ({red, yellow, green, phase} !== model_out()) begin
                errors++;
                $display("FAIL blink[%0d]: got %b, required %b", i, {red, yellow, green, phase}, model_out());
            end
        end
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL blink_101: seen=%b, required 1", seen);
        end
    endtask

    task automatic test_service_exit();
        int n;
        n = 0;
        while (((m_bpos / B_N) % 2) == 0 && n < 10) begin
            tick();
            n++;
        end
        service = 1'b0;
        tick();
        checks++;
        if ({red, yellow, green, phase} !== {3'b100, RED}) begin
            errors++;
            $display("FAIL service_exit: got %b, required %b", {red, yellow, green, phase}, {3'b100, RED});
        end
        for (int i = 0; i < R_N + 1; i++) begin
            tick();
            checks++;
            if ({red, yellow, green, phase} !== model_out()) begin
                errors++;
                $display("FAIL exit_seq[%0d]: got %b, required %b", i, {red, yellow, green, phase}, model_out());
            end
        end
    endtask

    task automatic test_reset_midrun();
        run_until_pos(R_N + RY_N + G_N);
        rst = 1'b1; start = 1'b1; service = 1'b1;
        tick();
        checks++;
        if ({red, yellow, green, phase} !== {3'b000, IDLE}) begin
            errors++;
            $display("FAIL reset_mid: got %b, required %b", {red, yellow, green, phase}, {3'b000, IDLE});
        end
        rst = 1'b0; start = 1'b0; service = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({red, yellow, green, phase} !== {3'b000, IDLE}) begin
                errors++;
                $display("FAIL stay_idle[%0d]: got %b, required %b", i, {red, yellow, green, phase}, {3'b000, IDLE});
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({red, yellow, green, phase} !== {3'b100, RED}) begin
            errors++;
            $display("FAIL restart: got %b, required %b", {red, yellow, green, phase}, {3'b100, RED});
        end
    endtask

    task automatic test_start_ignored();
        for (int i = 0; i < PERIOD + 2; i++) begin
            start = (i == 1 || i == 6) ? 1'b1 : 1'b0;
            tick();
            checks++;
            if ({red, yellow, green, phase} !== model_out()) begin
                errors++;
                $display("FAIL start_ignored[%0d]: got %b, required %b", i, {red, yellow, green, phase}, model_out());
            end
        end
        rst = 1'b1; start = 1'b0;
        tick();
        rst = 1'b0; en = 1'b0; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({red, yellow, green, phase} !== {3'b000, IDLE}) begin
                errors++;
                $display("FAIL idle_frozen[%0d]: got %b, required %b", i, {red, yellow, green, phase}, {3'b000, IDLE});
            end
        end
        start = 1'b0; en = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 99) < 2);
            en    = ($urandom_range(0, 99) < 80);
            start = ($urandom_range(0, 99) < 20);
            if ($urandom_range(0, 99) < 8) service = ~service;
            tick();
            checks++;
            if ({red, yellow, green, phase} !== model_out()) begin
                errors++;
                $display("FAIL random[%0d]: got %b, required %b", i, {red, yellow, green, phase}, model_out());
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_normal_cycle();
        test_freeze();
        test_service();
        test_service_exit();
        test_reset_midrun();
        test_start_ignored();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
